// File: rtl/tpu_output_collector.sv
// tpu_output_collector
//   Collects skewed column results from a systolic array, realigns them into
//   rows, requantises every element to dataSize bits (round, arithmetic shift,
//   saturate, optional ReLU) and queues the packed rows in a
//   first-word-fall-through FIFO that feeds a valid/ready output stream.
//   A small run controller (IDLE -> COLLECT -> DRAIN -> DONE) counts rows and
//   pulses flag_done once the requested rows have all left the block.
//
// Ports
//   clk, nrst        clock (rising edge), asynchronous active-low reset
//   matrix_out[j]    signed column results; column j lags column 0 by j cycles
//   in_valid         column 0 of a row is valid this cycle
//   cfg_shift        requantisation right shift (0..15)
//   cfg_relu         clamp negative results to zero
//   cfg_num_outputs  rows to collect per run
//   ctrl_start       start pulse, honoured only in IDLE
//   out_data         packed row, column 0 in the LSBs
//   out_valid/ready  output stream handshake
//   flag_done        one-cycle pulse at the end of a run
//   err_overflow     sticky: a row arrived while the FIFO was full
//   dbg_state        current controller state (0 IDLE, 1 COLLECT, 2 DRAIN, 3 DONE)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_data holds.
// out_valid never depends combinationally on out_ready.
module tpu_output_collector #(
  parameter int dataSize      = 8,
  parameter int numInChannel  = 1,
  parameter int numOutChannel = 3,
  parameter int fifoDepth     = 16,
  localparam int inSize = dataSize*2 + $clog2(numInChannel) + 1,
  localparam int outW   = numOutChannel*dataSize
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [inSize-1:0] matrix_out [numOutChannel],
  input  logic              in_valid,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_relu,
  input  logic [15:0]       cfg_num_outputs,
  input  logic              ctrl_start,
  output logic [outW-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              flag_done,
  output logic              err_overflow,
  output logic [1:0]        dbg_state
);

  localparam int aw = $clog2(fifoDepth);
  localparam logic [aw:0] depth_c = fifoDepth[aw:0];
  localparam logic signed [inSize:0] sat_hi = (inSize+1)'(2**(dataSize-1)-1);
  localparam logic signed [inSize:0] sat_lo = ~sat_hi;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state;
  logic [15:0] row_count;

  // Deskew: column j is delayed numOutChannel-1-j cycles so every column of
  // a row lines up with the last column. Runs in every state.
  logic [inSize-1:0] aligned [numOutChannel];
  logic              aligned_valid;

  for (genvar j = 0; j < numOutChannel; j++) begin : g_col
    localparam int len = numOutChannel - 1 - j;
    if (len == 0) begin : g_direct
      assign aligned[j] = matrix_out[j];
    end else begin : g_chain
      logic [inSize-1:0] chain [len];
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          for (int i = 0; i < len; i++) chain[i] <= '0;
        end else begin
          chain[0] <= matrix_out[j];
          for (int i = 1; i < len; i++) chain[i] <= chain[i-1];
        end
      end
      assign aligned[j] = chain[len-1];
    end
  end

  if (numOutChannel > 1) begin : g_vpipe
    logic [numOutChannel-2:0] vpipe;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= in_valid;
        for (int i = 1; i < numOutChannel-1; i++) vpipe[i] <= vpipe[i-1];
      end
    end
    assign aligned_valid = vpipe[numOutChannel-2];
  end else begin : g_vdirect
    assign aligned_valid = in_valid;
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [dataSize-1:0] requant(input logic [inSize-1:0] x,
                                                  input logic [3:0] sh,
                                                  input logic relu);
    logic signed [inSize:0] v;
    logic        [inSize:0] rnd;
    logic [dataSize-1:0]    r;
    v   = $signed({x[inSize-1], x});
    rnd = '0;
    if (sh != 4'd0) rnd = (inSize+1)'(1) << (sh - 4'd1);
    v = (v + $signed(rnd)) >>> sh;
    if (v > sat_hi)      r = sat_hi[dataSize-1:0];
    else if (v < sat_lo) r = sat_lo[dataSize-1:0];
    else                 r = v[dataSize-1:0];
    if (relu && r[dataSize-1]) r = '0;
    return r;
  endfunction

  logic [outW-1:0] row_q;
  always_comb begin
    row_q = '0;
    for (int j = 0; j < numOutChannel; j++)
      row_q[j*dataSize +: dataSize] = requant(aligned[j], cfg_shift, cfg_relu);
  end

  // Rows are admitted (and counted) only while collecting.
  logic accept;
  assign accept = aligned_valid && (state == COLLECT);

  logic            req_valid;
  logic [outW-1:0] req_data;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      req_valid <= 1'b0;
      req_data  <= '0;
    end else begin
      req_valid <= accept;
      if (accept) req_data <= row_q;
    end
  end

  // FIFO. A push into a full FIFO is still taken when a pop happens in the
  // same cycle, since the pop frees the slot being written.
  logic [outW-1:0] mem [fifoDepth];
  logic [aw-1:0]   wr_ptr, rd_ptr;
  logic [aw:0]     count;
  logic            full, pop, do_write, drop;

  assign full     = (count == depth_c);
  assign pop      = out_valid && out_ready;
  assign do_write = req_valid && (!full || pop);
  assign drop     = req_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= req_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + aw'(1);
      if (pop)      rd_ptr <= rd_ptr + aw'(1);
      case ({do_write, pop})
        2'b10:   count <= count + (aw+1)'(1);
        2'b01:   count <= count - (aw+1)'(1);
        default: ;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Run controller.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      row_count    <= '0;
      err_overflow <= 1'b0;
      flag_done    <= 1'b0;
    end else begin
      flag_done <= 1'b0;
      if (drop) err_overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            state        <= COLLECT;
            row_count    <= '0;
            err_overflow <= 1'b0;
          end
        end
        COLLECT: begin
          if (row_count == cfg_num_outputs) state <= DRAIN;
          if (accept) row_count <= row_count + 16'd1;
        end
        DRAIN: begin
          if (!out_valid && !req_valid) begin
            state     <= DONE;
            flag_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/tpu_output_collector.md
TPU_OUTPUT_COLLECTOR -- requirements
Module: tpu_output_collector

Interface
REQ-001 SHALL have parameter dataSize, default 8, the output element width in bits.
REQ-002 SHALL have parameter numInChannel, default 1, used only to derive the input width.
REQ-003 SHALL have parameter numOutChannel, default 3, the number of array columns (nPEx).
REQ-004 SHALL have parameter fifoDepth, default 16, a power of 2, the number of packed output words.
REQ-005 SHALL derive localparam inSize = dataSize*2 + $clog2(numInChannel) + 1, which is 17 at defaults.
REQ-006 SHALL have port clk, input, 1 bit, the clock; all state changes on the rising edge.
REQ-007 SHALL have port nrst, input, 1 bit, the reset: asynchronous, active-low.
REQ-008 SHALL have port matrix_out[numOutChannel], input, inSize bits each, the signed two's-complement column results from the systolic array.
REQ-009 SHALL have port in_valid, input, 1 bit, meaning column 0 is valid this cycle; column j's matching data arrives j cycles later.
REQ-010 SHALL have port cfg_shift, input, 4 bits, the requantisation right-shift amount (0..15).
REQ-011 SHALL have port cfg_relu, input, 1 bit, which clamps negative results to 0.
REQ-012 SHALL have port cfg_num_outputs, input, 16 bits, the number of rows to collect per run.
REQ-013 SHALL have port ctrl_start, input, 1 bit, a start pulse that is honoured only in IDLE.
REQ-014 SHALL have port out_data, output, numOutChannel*dataSize bits, with column 0 in the LSBs.
REQ-015 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit, forming the stream handshake.
REQ-016 SHALL have port flag_done, output, 1 bit, a one-cycle pulse at the end of a run.
REQ-017 SHALL have port err_overflow, output, 1 bit, a sticky flag set when a row is dropped.

Function
REQ-018 SHALL deskew: column j passes through numOutChannel-1-j registers, and in_valid passes through numOutChannel-1 registers, so all columns of a row align.
REQ-019 SHALL requantise each aligned element in one registered stage: add 2^(cfg_shift-1) if cfg_shift>0, then arithmetic shift right by cfg_shift, then saturate to [-2^(dataSize-1), 2^(dataSize-1)-1], then apply cfg_relu.
REQ-020 SHALL perform the intermediate arithmetic at inSize+1 bits so the rounding add never wraps.
REQ-021 SHALL push the packed row into the FIFO numOutChannel cycles after column 0's in_valid (2 deskew + 1 requant stages at defaults), but only in state COLLECT.
REQ-022 SHALL make the FIFO first-word-fall-through: out_valid asserts the cycle after the first push into an empty FIFO.
REQ-023 SHALL pop the FIFO on out_valid && out_ready.
REQ-024 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL accept a simultaneous push and pop when the FIFO is full, leaving the count unchanged and no row dropped.
REQ-026 SHALL drop a row that arrives when the FIFO is full with no pop, set err_overflow, and still count the row.
REQ-027 SHALL keep 16-bit row_count incremented on every aligned row in COLLECT.
REQ-028 SHALL implement the state machine IDLE -> COLLECT -> DRAIN -> DONE -> IDLE.
REQ-029 SHALL, in IDLE on ctrl_start, go to COLLECT and clear row_count and err_overflow; the FIFO contents are retained.
REQ-030 SHALL go from COLLECT to DRAIN when row_count reaches cfg_num_outputs.
REQ-031 SHALL, in IDLE on ctrl_start with cfg_num_outputs=0, pass through COLLECT to DRAIN on the next cycle.
REQ-032 SHALL go from DRAIN to DONE when the FIFO is empty and the requant stage holds no row.
REQ-033 SHALL assert flag_done=1 in DONE for exactly one cycle, then return to IDLE.
REQ-034 SHALL ignore ctrl_start outside IDLE.
REQ-035 SHALL ignore aligned rows outside COLLECT: no push and no count.
REQ-036 SHALL keep the deskew pipeline shifting in every state.
REQ-037 SHALL sample cfg_* every cycle; cfg_* SHALL be stable from ctrl_start until flag_done.

Reset
REQ-038 SHALL, on nrst=0, asynchronously set state=IDLE, row_count=0, FIFO pointers=0, all pipeline valids=0, out_valid=0, out_data=0, flag_done=0 and err_overflow=0.
REQ-039 SHALL, when reset is asserted mid-run, abandon the run and discard all FIFO contents.
REQ-040 SHALL produce no output activity after reset release until the next ctrl_start.

Verification
REQ-041 SHALL cover basic requantisation: cfg_shift=4, relu=0, one row of columns 40, -40, 5000 -> out_data=0x7FFE03, with out_valid 4 cycles after column 0's in_valid.
REQ-042 SHALL cover ReLU and passthrough: the same row with relu=1 -> 0x7F0003; cfg_shift=0 with values 127, -128, 0 -> 0x00807F.
REQ-043 SHALL cover run completion: cfg_num_outputs=5, 5 back-to-back rows, out_ready=1 -> 5 words out, then exactly one flag_done pulse, then IDLE.
REQ-044 SHALL cover backpressure: out_ready=0 and 17 rows -> 16 words stored, err_overflow=1; then out_ready=1 -> the first 16 rows in order, and the 17th row is never output.
REQ-045 SHALL cover start edge cases: cfg_num_outputs=0 -> flag_done pulse 3 cycles after ctrl_start; a ctrl_start during COLLECT changes nothing.
REQ-046 SHALL cover reset mid-run: nrst pulsed low after 2 rows -> out_valid=0 and flag_done=0; a new run after release completes cleanly.
